// File: rtl/keypad_scan_if.sv
// Keypad-side bundle: row sense lines in, column strobes and key report out.
// clk and clr stay plain ports on the scanner itself.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_pressed;

    modport master (
        input  row,
        output col,
        output key_valid,
        output key_code,
        output key_pressed
    );

    modport slave (
        output row,
        input  col,
        input  key_valid,
        input  key_code,
        input  key_pressed
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounced press/release detection.
// One key_valid pulse per press; key_code = row*4 + col.
module keypad_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int DB_TICKS = 20
) (
    input  logic          clk,
    input  logic          clr,
    keypad_scan_if.master kp
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DB_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        SCAN,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    row_m_q, row_s_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx;
    logic          kv_q, kv_d;
    logic          kp_q, kp_d;
    logic [3:0]    code_q, code_d;
    logic          tick, row_any, db_done;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            row_m_q   <= 4'hF;
            row_s_q   <= 4'hF;
            tick_q    <= '0;
            db_cnt_q  <= '0;
            col_idx_q <= 2'd0;
            kv_q      <= 1'b0;
            kp_q      <= 1'b0;
            code_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            row_m_q   <= kp.row;
            row_s_q   <= row_m_q;
            tick_q    <= tick_d;
            db_cnt_q  <= db_cnt_d;
            col_idx_q <= col_idx_d;
            kv_q      <= kv_d;
            kp_q      <= kp_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        tick    = (tick_q == TICK_LAST);
        tick_d  = tick ? '0 : tick_q + TW'(1);
        row_any = (row_s_q != 4'hF);
        db_inc  = db_cnt_q + DW'(1);
        db_done = (db_inc == DB_LAST);
    end

    // Lowest-numbered low row wins when several rows respond.
    always_comb begin
        row_idx = 2'd0;
        priority case (1'b1)
            !row_s_q[0]: row_idx = 2'd0;
            !row_s_q[1]: row_idx = 2'd1;
            !row_s_q[2]: row_idx = 2'd2;
            !row_s_q[3]: row_idx = 2'd3;
            default:     row_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        col_idx_d = col_idx_q;
        kv_d      = 1'b0;
        kp_d      = kp_q;
        code_d    = code_q;
        unique case (state_q)
            IDLE: begin
                if (tick && row_any) begin
                    state_d  = DEBOUNCE;
                    db_cnt_d = '0;
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!row_any) begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end else if (db_done) begin
                        state_d   = SCAN;
                        db_cnt_d  = '0;
                        col_idx_d = 2'd0;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
            end
            SCAN: begin
                if (tick) begin
                    if (row_any) begin
                        code_d   = {row_idx, col_idx_q};
                        kv_d     = 1'b1;
                        kp_d     = 1'b1;
                        db_cnt_d = '0;
                        state_d  = HOLD;
                    end else if (col_idx_q != 2'd3) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                // Only the found column is strobed, so other columns are invisible here.
                if (tick) begin
                    if (row_any) begin
                        db_cnt_d = '0;
                    end else if (db_done) begin
                        db_cnt_d = '0;
                        kp_d     = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        kp.col = 4'b0000;
        if (state_q == SCAN || state_q == HOLD) begin
            kp.col = ~(4'b0001 << col_idx_q);
        end
    end

    assign kp.key_valid   = kv_q;
    assign kp.key_code    = code_q;
    assign kp.key_pressed = kp_q;
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 100000, meaning the number of clk cycles per scan tick (1 ms at 100 MHz).
REQ-002 The module SHALL have parameter DB_TICKS, default 20, meaning the number of consecutive scan ticks required to confirm a press or a release.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 clr  input  1  synchronous, active-high reset.
REQ-006 row  input  4  keypad row lines; active-low; pulled up when no key is pressed; asynchronous to clk.
REQ-007 col  output  4  keypad column strobes; a driven column is low.
REQ-008 key_valid  output  1  one-cycle pulse when a new key press is confirmed.
REQ-009 key_code  output  4  code of the last confirmed key, equal to row_index*4 + col_index.
REQ-010 key_pressed  output  1  level; high from the key_valid cycle until the release is confirmed.

Function
REQ-011 The module SHALL pass row through a 2-flop synchronizer (row_s); all row decisions SHALL use row_s only.
REQ-012 The tick counter SHALL count 0..SCAN_DIV-1 and wrap, with tick=1 for the one cycle where the count equals SCAN_DIV-1.
REQ-013 The tick counter SHALL run freely in every state.
REQ-014 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, SCAN, HOLD.
REQ-015 In IDLE, col SHALL be 4'b0000; on a tick with row_s != 4'b1111, the FSM SHALL go to DEBOUNCE and clear db_cnt.
REQ-016 In DEBOUNCE, col SHALL be 4'b0000; on each tick with row_s != 4'b1111, db_cnt SHALL increment.
REQ-017 When db_cnt reaches DB_TICKS in DEBOUNCE, the FSM SHALL go to SCAN with col_idx=0.
REQ-018 On a tick in DEBOUNCE with row_s == 4'b1111, the FSM SHALL return to IDLE without asserting key_valid.
REQ-019 In SCAN, col SHALL be ~(4'b0001 << col_idx); on each tick, row_s SHALL be sampled for the current column.
REQ-020 On a SCAN tick with any row_s bit low, key_code SHALL be loaded with {row_idx[1:0], col_idx[1:0]}, where row_idx is the lowest-numbered low bit of row_s.
REQ-021 On that SCAN hit, key_valid SHALL be 1 in the next cycle, key_pressed SHALL go to 1, db_cnt SHALL clear, and the FSM SHALL enter HOLD.
REQ-022 On a SCAN tick with row_s == 4'b1111 and col_idx < 3, col_idx SHALL increment; when col_idx == 3, the FSM SHALL return to IDLE with no key_valid.
REQ-023 In HOLD, col SHALL keep strobing the found column.
REQ-024 In HOLD, db_cnt SHALL increment on each tick with row_s == 4'b1111 and clear on each tick with row_s != 4'b1111.
REQ-025 When db_cnt reaches DB_TICKS in HOLD, key_pressed SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-026 Only one key_valid pulse SHALL occur per press, however long the key is held.
REQ-027 key_valid SHALL be exactly one clk wide, and there SHALL be at least DB_TICKS ticks between two key_valid pulses.
REQ-028 key_code SHALL hold its value until the next hit and SHALL be unaffected by release.
REQ-029 Press-to-key_valid latency SHALL be at most (DB_TICKS+5)*SCAN_DIV + 3 clk cycles.
REQ-030 If several keys are pressed, the lowest column is scanned first and the lowest row within that column wins; this SHALL be deterministic.
REQ-031 A key pressed in a different column during HOLD SHALL be ignored until the release is confirmed.

Reset
REQ-032 On clr=1 at a clk edge, the module SHALL set state=IDLE, tick counter=0, db_cnt=0, col_idx=0, and clear both synchronizer stages to 4'b1111.
REQ-033 On clr=1 at a clk edge, the outputs SHALL reset to col=4'b0000, key_valid=0, key_code=4'h0, key_pressed=0.
REQ-034 clr SHALL take priority over every other event, including a tick in the same cycle.
REQ-035 clr asserted in DEBOUNCE, SCAN or HOLD SHALL abort the operation with no key_valid pulse.
REQ-036 After clr, a key still held SHALL be re-debounced and reported once.

Verification (SCAN_DIV=4, DB_TICKS=2; the keypad model drives row[r]=0 when key (r,c) is closed and col[c]=0)
REQ-037 Press key r=2,c=1 for 40 ticks, then release -> exactly one key_valid, key_code=4'h9, key_pressed high until 2 ticks after release, then IDLE with col=4'b0000.
REQ-038 Drive a 1-tick glitch row=4'b1110 in IDLE -> DEBOUNCE returns to IDLE; key_valid never asserts; key_code stays 4'h0.
REQ-039 Press keys (0,3) and (3,0) together -> key_valid once with key_code=4'hC (column 0 scanned first); then release both -> key_pressed=0.
REQ-040 During HOLD, bounce the release as 1 tick open / 1 tick closed, repeated 3 times, then open -> key_pressed stays 1 until 2 consecutive open ticks; no second key_valid.
REQ-041 Assert clr for 1 cycle in SCAN with key (1,2) held -> outputs return to reset values the next cycle; after re-debounce, one key_valid with key_code=4'h6.
REQ-042 Drive the SCAN pass with no row response (key removed after DEBOUNCE) -> col steps through 1110, 1101, 1011, 0111, one tick each, then IDLE; no key_valid.
